// File: rtl/axis_frame_sender.sv
// axis_frame_sender: buffers a frame through a write port and streams it out as AXI-Stream with TLAST and a done pulse.
// start_ack/busy are decoded combinationally so they mark the accepting IDLE cycle itself.
module axis_frame_sender #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  input  logic                  start,
  output logic                  start_ack,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_SEND, S_DONE} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [ADDR_WIDTH-1:0] w_len;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_hs;
  logic                  w_wr;

  assign start_ack     = (r_state == S_IDLE) & start & ~rst;
  assign busy          = start_ack | (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

  always_comb begin
    w_hs      = r_tvalid & m_axis_tready;
    w_len     = (frame_len > ADDR_WIDTH'(DEPTH)) ? ADDR_WIDTH'(DEPTH) : frame_len;
    w_wr      = wr_en & (r_state == S_IDLE) & ~start_ack & (wr_addr < ADDR_WIDTH'(DEPTH));
    // r_rd_data always holds the word after the one on the bus, so a handshake never stalls
    w_rd_addr = (r_state == S_PREFETCH) ? ADDR_WIDTH'(1) :
                (r_state == S_SEND) ? r_idx + (w_hs ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1)) :
                '0;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[wr_addr] <= wr_data;
    if (w_rd_addr < ADDR_WIDTH'(DEPTH)) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= w_len;
            r_idx   <= '0;
            r_state <= (w_len == '0) ? S_DONE : S_PREFETCH;
          end
        end
        S_PREFETCH: begin
          r_tdata  <= r_rd_data;
          r_tvalid <= 1'b1;
          r_tlast  <= (r_len == ADDR_WIDTH'(1));
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_hs && r_tlast) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_hs) begin
            r_idx   <= r_idx + ADDR_WIDTH'(1);
            r_tdata <= r_rd_data;
            r_tlast <= (r_idx + ADDR_WIDTH'(2) == r_len);
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_frame_sender.sv
// tb_axis_frame_sender: scoreboard bench for axis_frame_sender; expected beats are queued at start and popped on each handshake.
module tb_axis_frame_sender;
  localparam int DW = 8;
  localparam int DEP = 784;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] frame_len = '0;
  logic          start = 1'b0;
  logic          start_ack;
  logic          busy;
  logic          done;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  axis_frame_sender #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_len(frame_len), .start(start), .start_ack(start_ack), .busy(busy), .done(done),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_ack = -1, t_done = -1, t_lasths = -1, first_v = -1;
  int n_done = 0, n_ack = 0, n_beats = 0, n_last = 0;
  logic [DW-1:0] mdl [DEP];
  logic [DW:0] q [$];
  logic bp [$];
  logic hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic hold_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp.size() != 0) m_axis_tready = bp.pop_front();
  end

  logic [DW:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      if (start_ack) begin t_ack = cyc; n_ack++; end
      if (done) begin t_done = cyc; n_done++; end
      if (m_axis_tvalid && first_v < 0) first_v = cyc;
      if (hold) begin
        check("stable_valid", m_axis_tvalid, 1);
        check("stable_data", m_axis_tdata, hold_data);
        check("stable_last", m_axis_tlast, hold_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        if (m_axis_tlast) begin n_last++; t_lasths = cyc; end
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("tdata", m_axis_tdata, e[DW-1:0]);
          check("tlast", m_axis_tlast, e[DW]);
        end
      end
      hold = m_axis_tvalid & ~m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
    end
  end

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    if (a < DEP) mdl[a] = d;
  endtask

  task automatic wr_end();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input int len);
    int l;
    l = (len > DEP) ? DEP : len;
    for (int i = 0; i < l; i++) q.push_back({i == l - 1, mdl[i]});
  endtask

  task automatic start_pulse(input int len);
    first_v = -1;
    push_exp(len);
    @(posedge clk); #1;
    frame_len = AW'(len); start = 1'b1;
    @(negedge clk); #1;
    check("start_ack", start_ack, 1);
    check("busy_at_ack", busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int target;
    target = n_done + 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_done >= target) break;
    end
    check("done_timeout", n_done, target);
  endtask

  int b, a0, l0, d1;
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", m_axis_tlast, 0);
    check("rst_data", m_axis_tdata, 0);
    for (int i = 0; i < 4; i++) wr(i, DW'(8'h10 + i));
    wr(900, 8'hAA);
    wr_end();
    // basic frame
    start_pulse(4);
    wait_done(50);
    check("basic_first_valid", first_v - t_ack, 2);
    check("basic_last", t_lasths - t_ack, 5);
    check("basic_done", t_done - t_ack, 6);
    @(negedge clk); #1;
    check("basic_busy_low", busy, 0);
    // backpressure
    bp = '{1, 1, 1, 0, 0, 1, 0, 1, 1};
    b = n_beats;
    start_pulse(4);
    wait_done(50);
    check("bp_beats", n_beats - b, 4);
    check("bp_last_time", t_lasths - t_ack, 8);
    check("bp_done_after_last", t_done - t_lasths, 1);
    // zero length
    start_pulse(0);
    wait_done(20);
    check("len0_done", t_done - t_ack, 1);
    check("len0_no_valid", first_v, -1);
    // single beat
    l0 = n_last;
    start_pulse(1);
    wait_done(20);
    check("len1_last", n_last - l0, 1);
    // ignored start and write mid-frame
    a0 = n_ack;
    start_pulse(4);
    @(posedge clk); #1;
    start = 1'b1; wr_en = 1'b1; wr_addr = 2; wr_data = 8'hFF;
    @(negedge clk); #1;
    check("busy_no_ack", start_ack, 0);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done(50);
    check("ignored_acks", n_ack - a0, 1);
    // reset mid-frame
    b = n_beats;
    d1 = n_done;
    start_pulse(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (n_beats - b >= 2) break;
    end
    check("mid_beats", n_beats - b, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    hold = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_valid", m_axis_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last", m_axis_tlast, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", n_done, d1);
    start_pulse(4);
    wait_done(50);
    // back-to-back with start held
    a0 = n_ack; b = n_beats; l0 = n_last;
    push_exp(3);
    push_exp(3);
    @(posedge clk); #1;
    frame_len = 3; start = 1'b1;
    wait_done(50);
    d1 = t_done;
    wait_done(50);
    start = 1'b0;
    check("b2b_ack_gap", t_ack - d1, 1);
    check("b2b_acks", n_ack - a0, 2);
    check("b2b_beats", n_beats - b, 6);
    check("b2b_lasts", n_last - l0, 2);
    // full buffer, clamped length
    for (int i = 0; i < DEP; i++) wr(i, DW'($urandom_range(0, 255)));
    wr_end();
    b = n_beats; l0 = n_last;
    start_pulse(1000);
    wait_done(2000);
    check("clamp_beats", n_beats - b, DEP);
    check("clamp_lasts", n_last - l0, 1);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
